// File: rtl/setup_scheduler.sv
// Setup scheduler: owns the committed lock configuration and time-shares keypad/display
// between the operating and setup modules. Define SETUP_TIMEOUT_EN to build the inactivity abort.
package setup_scheduler_pkg;

    typedef logic [5:0][3:0] bcdPac_t;

    typedef struct packed {
        logic            bip_status;
        logic [6:0]      bip_time;
        logic [6:0]      tranca_aut_time;
        logic [4:0][3:0] master_pin;
        logic [4:0][3:0] pin1;
        logic [4:0][3:0] pin2;
        logic [4:0][3:0] pin3;
        logic [4:0][3:0] pin4;
    } setupPac_t;

    typedef enum logic [1:0] {
        OPERACAO,
        SETUP_ATIVO,
        ABORTAR,
        AGUARDAR_FIM
    } sched_state_t;

    localparam setupPac_t SETUP_FACTORY = '{
        bip_status:      1'b1,
        bip_time:        7'd5,
        tranca_aut_time: 7'd5,
        master_pin:      {4'h1, 4'h1, 4'h2, 4'h3, 4'h4},
        pin1:            {4'h1, 4'h0, 4'h0, 4'h0, 4'h0},
        pin2:            {4'h0, 4'hF, 4'hF, 4'hF, 4'hF},
        pin3:            {4'h0, 4'hF, 4'hF, 4'hF, 4'hF},
        pin4:            {4'h0, 4'hF, 4'hF, 4'hF, 4'hF}
    };

endpackage

module setup_scheduler
    import setup_scheduler_pkg::*;
#(
    parameter logic [31:0] SETUP_TIMEOUT_CYC = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       setup_req,
    output logic       op_key_valid,
    output logic [3:0] op_key_code,
    output logic       st_key_valid,
    output logic [3:0] st_key_code,
    input  bcdPac_t    op_bcd,
    input  logic       op_bcd_enable,
    input  bcdPac_t    st_bcd,
    input  logic       st_bcd_enable,
    output bcdPac_t    bcd_out,
    output logic       bcd_enable,
    output logic       setup_on,
    input  logic       setup_end,
    output logic       setup_rst,
    input  setupPac_t  data_setup_new,
    output setupPac_t  data_setup,
    output logic       setup_busy
);

    sched_state_t state_q;
    setupPac_t    data_setup_q;
    logic         setup_on_q;
    logic         setup_busy_q;
    logic         setup_req_q;
    logic         req_rise;

    logic         op_key_valid_q, op_key_valid_d;
    logic [3:0]   op_key_code_q,  op_key_code_d;
    logic         st_key_valid_q, st_key_valid_d;
    logic [3:0]   st_key_code_q,  st_key_code_d;
    bcdPac_t      bcd_out_q,      bcd_out_d;
    logic         bcd_enable_q,   bcd_enable_d;

    assign req_rise = setup_req & ~setup_req_q;

`ifdef SETUP_TIMEOUT_EN
    localparam logic [31:0] CNT_LAST = SETUP_TIMEOUT_CYC - 32'd1;

    logic [31:0] cnt_q;
    logic        key_valid_q;
    logic        key_rise;
    logic        setup_rst_q;

    assign key_rise  = key_valid & ~key_valid_q;
    assign setup_rst = setup_rst_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^SETUP_TIMEOUT_CYC;
    assign setup_rst          = 1'b0;
`endif

    // Routing is chosen by the current state; the selected values are registered below.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can be inferred.
        op_key_valid_d = 1'b0;
        op_key_code_d  = 4'h0;
        st_key_valid_d = 1'b0;
        st_key_code_d  = 4'h0;
        bcd_out_d      = '1;
        bcd_enable_d   = 1'b1;
        case (state_q)
            OPERACAO: begin
                op_key_valid_d = key_valid;
                op_key_code_d  = key_code;
                bcd_out_d      = op_bcd;
                bcd_enable_d   = op_bcd_enable;
            end
            SETUP_ATIVO: begin
                st_key_valid_d = key_valid;
                st_key_code_d  = key_code;
                bcd_out_d      = st_bcd;
                bcd_enable_d   = st_bcd_enable;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q        <= OPERACAO;
            data_setup_q   <= SETUP_FACTORY;
            setup_on_q     <= 1'b0;
            setup_busy_q   <= 1'b0;
            setup_req_q    <= 1'b0;
            op_key_valid_q <= 1'b0;
            op_key_code_q  <= 4'h0;
            st_key_valid_q <= 1'b0;
            st_key_code_q  <= 4'h0;
            bcd_out_q      <= '1;
            bcd_enable_q   <= 1'b0;
`ifdef SETUP_TIMEOUT_EN
            cnt_q          <= 32'd0;
            key_valid_q    <= 1'b0;
            setup_rst_q    <= 1'b0;
`endif
        end else begin
            setup_req_q    <= setup_req;
            op_key_valid_q <= op_key_valid_d;
            op_key_code_q  <= op_key_code_d;
            st_key_valid_q <= st_key_valid_d;
            st_key_code_q  <= st_key_code_d;
            bcd_out_q      <= bcd_out_d;
            bcd_enable_q   <= bcd_enable_d;
`ifdef SETUP_TIMEOUT_EN
            key_valid_q    <= key_valid;
`endif
            case (state_q)
                OPERACAO: begin
                    if (req_rise && setup_end) begin
                        state_q      <= SETUP_ATIVO;
                        setup_on_q   <= 1'b1;
                        setup_busy_q <= 1'b1;
                    end
                end
                SETUP_ATIVO: begin
                    // Commit has priority over both the key edge and the timeout.
                    if (!setup_end) begin
                        data_setup_q <= data_setup_new;
                        setup_on_q   <= 1'b0;
                        state_q      <= AGUARDAR_FIM;
`ifdef SETUP_TIMEOUT_EN
                        cnt_q        <= 32'd0;
                    end else if (key_rise) begin
                        cnt_q        <= 32'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        setup_on_q   <= 1'b0;
                        setup_rst_q  <= 1'b1;
                        cnt_q        <= 32'd0;
                        state_q      <= ABORTAR;
                    end else if (cnt_q != '1) begin
                        cnt_q        <= cnt_q + 32'd1;
`endif
                    end
                end
                ABORTAR: begin
`ifdef SETUP_TIMEOUT_EN
                    setup_rst_q <= 1'b0;
`endif
                    state_q     <= AGUARDAR_FIM;
                end
                AGUARDAR_FIM: begin
                    if (setup_end) begin
                        state_q      <= OPERACAO;
                        setup_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= OPERACAO;
                    setup_on_q   <= 1'b0;
                    setup_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign op_key_valid = op_key_valid_q;
    assign op_key_code  = op_key_code_q;
    assign st_key_valid = st_key_valid_q;
    assign st_key_code  = st_key_code_q;
    assign bcd_out      = bcd_out_q;
    assign bcd_enable   = bcd_enable_q;
    assign setup_on     = setup_on_q;
    assign setup_busy   = setup_busy_q;
    assign data_setup   = data_setup_q;

endmodule

// File: tb/tb_setup_scheduler.sv
// Directed bench for setup_scheduler: routing, commit handshake, reset and (when built with
// SETUP_TIMEOUT_EN) the inactivity abort, using a 20-cycle timeout.
module tb_setup_scheduler;
    import setup_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       setup_req;
    logic       op_key_valid, st_key_valid;
    logic [3:0] op_key_code, st_key_code;
    bcdPac_t    op_bcd, st_bcd, bcd_out;
    logic       op_bcd_enable, st_bcd_enable, bcd_enable;
    logic       setup_on, setup_end, setup_rst, setup_busy;
    setupPac_t  data_setup_new, data_setup;

    setupPac_t  exp_fact, cfg30, cfg45;
    int         total = 0;
    int         bad   = 0;
    int         rst_hits, first_hit;
    bcdPac_t    bcd_mid;

    always #5 clk = ~clk;

    setup_scheduler #(.SETUP_TIMEOUT_CYC(32'd20)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_code(key_code), .setup_req(setup_req),
        .op_key_valid(op_key_valid), .op_key_code(op_key_code),
        .st_key_valid(st_key_valid), .st_key_code(st_key_code),
        .op_bcd(op_bcd), .op_bcd_enable(op_bcd_enable),
        .st_bcd(st_bcd), .st_bcd_enable(st_bcd_enable),
        .bcd_out(bcd_out), .bcd_enable(bcd_enable),
        .setup_on(setup_on), .setup_end(setup_end), .setup_rst(setup_rst),
        .data_setup_new(data_setup_new), .data_setup(data_setup),
        .setup_busy(setup_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_fact.bip_status      = 1'b1;
        exp_fact.bip_time        = 7'd5;
        exp_fact.tranca_aut_time = 7'd5;
        exp_fact.master_pin      = 20'h11234;
        exp_fact.pin1            = 20'h10000;
        exp_fact.pin2            = 20'h0FFFF;
        exp_fact.pin3            = 20'h0FFFF;
        exp_fact.pin4            = 20'h0FFFF;
        cfg30 = exp_fact;
        cfg30.bip_time = 7'd30;
        cfg45 = cfg30;
        cfg45.bip_time = 7'd45;

        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; setup_req = 1'b0; setup_end = 1'b1;
        op_bcd = 24'h123456; op_bcd_enable = 1'b1;
        st_bcd = 24'h654321; st_bcd_enable = 1'b1;
        data_setup_new = cfg30;
        tick(); tick();

        check("rst_bip_time",  128'(data_setup.bip_time), 128'(7'd5));
        check("rst_pin1",      128'(data_setup.pin1), 128'(20'h10000));
        check("rst_cfg",       128'(data_setup), 128'(exp_fact));
        check("rst_setup_on",  128'(setup_on), 128'(1'b0));
        check("rst_busy",      128'(setup_busy), 128'(1'b0));
        check("rst_setup_rst", 128'(setup_rst), 128'(1'b0));
        check("rst_bcd_out",   128'(bcd_out), 128'(24'hFFFFFF));
        check("rst_bcd_en",    128'(bcd_enable), 128'(1'b0));

        // Operating-mode routing with one cycle of latency.
        rst = 1'b0; key_valid = 1'b1; key_code = 4'h3;
        #1;
        check("op_key_before_edge", 128'(op_key_valid), 128'(1'b0));
        tick();
        check("op_key_valid", 128'(op_key_valid), 128'(1'b1));
        check("op_key_code",  128'(op_key_code), 128'(4'h3));
        check("op_st_valid",  128'(st_key_valid), 128'(1'b0));
        check("op_bcd_out",   128'(bcd_out), 128'(24'h123456));
        check("op_bcd_en",    128'(bcd_enable), 128'(1'b1));
        key_valid = 1'b0; key_code = 4'h0;
        tick();

        // Request while setup_end is low is ignored.
        setup_end = 1'b0; setup_req = 1'b1; tick();
        setup_req = 1'b0; tick();
        check("req_blocked_busy", 128'(setup_busy), 128'(1'b0));
        check("req_blocked_on",   128'(setup_on), 128'(1'b0));
        setup_end = 1'b1; tick();

        // Session with commit of bip_time=30.
        setup_req = 1'b1; tick();
        check("enter_setup_on", 128'(setup_on), 128'(1'b1));
        check("enter_busy",     128'(setup_busy), 128'(1'b1));
        setup_req = 1'b0; key_valid = 1'b1; key_code = 4'h7; tick();
        check("st_key_valid", 128'(st_key_valid), 128'(1'b1));
        check("st_key_code",  128'(st_key_code), 128'(4'h7));
        check("st_op_valid",  128'(op_key_valid), 128'(1'b0));
        check("st_bcd_out",   128'(bcd_out), 128'(24'h654321));
        key_valid = 1'b0; setup_end = 1'b0; tick();
        check("commit_bip_time", 128'(data_setup.bip_time), 128'(7'd30));
        check("commit_setup_on", 128'(setup_on), 128'(1'b0));
        check("commit_busy",     128'(setup_busy), 128'(1'b1));
        key_valid = 1'b1; key_code = 4'h9; tick();
        check("wait_bcd_out",  128'(bcd_out), 128'(24'hFFFFFF));
        check("wait_bcd_en",   128'(bcd_enable), 128'(1'b1));
        check("wait_st_valid", 128'(st_key_valid), 128'(1'b0));
        check("wait_op_valid", 128'(op_key_valid), 128'(1'b0));
        key_valid = 1'b0; setup_end = 1'b1; tick();
        check("back_busy", 128'(setup_busy), 128'(1'b0));
        tick();
        check("back_bcd_out", 128'(bcd_out), 128'(24'h123456));

`ifdef SETUP_TIMEOUT_EN
        // Abort after 20 idle cycles: setup_rst high for one cycle, 20 edges after entry.
        setup_req = 1'b1; tick(); setup_req = 1'b0;
        rst_hits = 0; first_hit = 0; bcd_mid = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (setup_rst === 1'b1) begin
                rst_hits++;
                if (first_hit == 0) first_hit = i;
            end
            if (i == 21) bcd_mid = bcd_out;
        end
        check("abort_first_cycle", 128'(first_hit), 128'(20));
        check("abort_pulse_width", 128'(rst_hits), 128'(1));
        check("abort_cfg_kept",    128'(data_setup), 128'(cfg30));
        check("abort_bcd_blank",   128'(bcd_mid), 128'(24'hFFFFFF));
        check("abort_setup_on",    128'(setup_on), 128'(1'b0));
        check("abort_busy",        128'(setup_busy), 128'(1'b0));

        // A key every 10 cycles keeps the session alive.
        setup_req = 1'b1; tick(); setup_req = 1'b0;
        rst_hits = 0;
        for (int i = 1; i <= 45; i++) begin
            key_valid = (i % 10 == 5);
            tick();
            if (setup_rst === 1'b1) rst_hits++;
        end
        key_valid = 1'b0;
        check("keys_no_abort", 128'(rst_hits), 128'(0));
        check("keys_setup_on", 128'(setup_on), 128'(1'b1));

        // Key edge in the timeout cycle wins and clears the counter.
        for (int i = 0; i < 19; i++) tick();
        key_valid = 1'b1; tick();
        check("keywin_no_rst",   128'(setup_rst), 128'(1'b0));
        check("keywin_setup_on", 128'(setup_on), 128'(1'b1));
        key_valid = 1'b0;

        // Commit in the timeout cycle wins over the abort.
        for (int i = 0; i < 19; i++) tick();
        data_setup_new = cfg45; setup_end = 1'b0; tick();
        check("tie_no_rst",   128'(setup_rst), 128'(1'b0));
        check("tie_bip_time", 128'(data_setup.bip_time), 128'(7'd45));
        check("tie_setup_on", 128'(setup_on), 128'(1'b0));
        setup_end = 1'b1; tick(); tick();
        check("tie_after_rst",  128'(setup_rst), 128'(1'b0));
        check("tie_after_busy", 128'(setup_busy), 128'(1'b0));
`else
        // Without the timeout the session stays open while idle.
        setup_req = 1'b1; tick(); setup_req = 1'b0;
        rst_hits = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (setup_rst === 1'b1) rst_hits++;
        end
        check("idle_no_rst",   128'(rst_hits), 128'(0));
        check("idle_setup_on", 128'(setup_on), 128'(1'b1));
        check("idle_busy",     128'(setup_busy), 128'(1'b1));
        data_setup_new = cfg45; setup_end = 1'b0; tick();
        check("idle_commit", 128'(data_setup.bip_time), 128'(7'd45));
        setup_end = 1'b1; tick(); tick();
        check("idle_back_busy", 128'(setup_busy), 128'(1'b0));
`endif

        // Reset mid-session restores factory configuration.
        setup_req = 1'b1; tick(); setup_req = 1'b0;
        check("rst2_in_session", 128'(setup_on), 128'(1'b1));
        rst = 1'b1; tick();
        check("rst2_cfg",      128'(data_setup), 128'(exp_fact));
        check("rst2_setup_on", 128'(setup_on), 128'(1'b0));
        check("rst2_busy",     128'(setup_busy), 128'(1'b0));
        check("rst2_bcd_en",   128'(bcd_enable), 128'(1'b0));
        rst = 1'b0; tick();
        check("rst2_op_route", 128'(bcd_out), 128'(24'h123456));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/setup_scheduler.md
# setup_scheduler

Owns the committed lock configuration (`setupPac_t`) and time-shares the keypad and the six-digit BCD display between the operating module and the setup module. Runs the `setup_on`/`setup_end` handshake with the setup module, commits `data_setup_new` on completion and aborts a stalled session via an inactivity timeout. Sits at the top level between the keypad decoder, the display driver, the operating module and the setup module.

## Interface
- `SETUP_TIMEOUT_CYC`, default 32'd500_000_000: number of cycles without a key press before an active setup session is aborted.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `key_valid`  in  1  keypad strobe, held high while the key is down.
- `key_code`  in  4  keypad code; 4'hF means confirm.
- `setup_req`  in  1  request from the operating module after master PIN acceptance; rising edge acts.
- `op_key_valid`, `op_key_code`  out  1, 4  keypad routed to the operating module.
- `st_key_valid`, `st_key_code`  out  1, 4  keypad routed to the setup module.
- `op_bcd`, `op_bcd_enable`  in  bcdPac_t, 1  display request from the operating module.
- `st_bcd`, `st_bcd_enable`  in  bcdPac_t, 1  display request from the setup module.
- `bcd_out`, `bcd_enable`  out  bcdPac_t, 1  to the display driver.
- `setup_on`  out  1  setup session active, to the setup module.
- `setup_end`  in  1  from the setup module: idles high, drops low when the session is finished.
- `setup_rst`  out  1  one-cycle reset pulse to the setup module on abort.
- `data_setup_new`  in  setupPac_t  configuration proposed by the setup module.
- `data_setup`  out  setupPac_t  committed configuration. Feeds the setup module's `data_setup_old` input and the operating module.
- `setup_busy`  out  1  high in any state other than OPERACAO.

## Operation
- Reset values:
  - State: OPERACAO.
  - `setup_on`=0, `setup_rst`=0, `setup_busy`=0.
  - All key outputs 0. `bcd_out`=all 4'hF, `bcd_enable`=0.
  - Timeout counter 0. `setup_req` edge register 0.
  - `data_setup` factory defaults:
    - bip_status=1, bip_time=7'd5, tranca_aut_time=7'd5.
    - master_pin={1,1,2,3,4}.
    - pin1={1,0,0,0,0}.
    - pin2–pin4={0,F,F,F,F}.
- States:
  - OPERACAO: keys and display routed from/to the operating module. A `setup_req` rising edge with `setup_end`=1 moves to SETUP_ATIVO and sets `setup_on`<=1. The edge is ignored while `setup_end`=0.
  - SETUP_ATIVO: keys and display routed from/to the setup module.
    - A `key_valid` rising edge clears the timeout counter; otherwise the counter increments.
    - `setup_end`==0: `data_setup`<=`data_setup_new`, `setup_on`<=0, go to AGUARDAR_FIM.
    - Else, counter==SETUP_TIMEOUT_CYC-1: `setup_on`<=0, `setup_rst`<=1, go to ABORTAR. `data_setup` is unchanged.
  - ABORTAR: `setup_rst`<=0, go to AGUARDAR_FIM.
  - AGUARDAR_FIM: wait for `setup_end`==1, then go to OPERACAO.
- In ABORTAR and AGUARDAR_FIM:
  - Keys are dropped: both `*_key_valid`=0.
  - Display shows `bcd_out`=all 4'hF with `bcd_enable`=1.
- Routing follows the current state register. The unselected key output is held at valid=0, code=0.
- The commit copies the whole struct in a single cycle; partial updates never occur.

## Timing
- All outputs are registered.
- Key and display routing latency is 1 cycle: input at edge N appears at the output after edge N+1.
- `setup_req` edge to `setup_on`=1: 1 cycle after the edge is sampled.
- `setup_end` sampled low to `setup_on`=0 and new `data_setup` visible: the same single clock edge.
- `setup_rst` is high for exactly 1 cycle.
- Simultaneous events:
  - `setup_end` low and timeout in the same cycle: commit wins, no abort.
  - Key edge and timeout in the same cycle: the key wins and the counter clears.
  - `setup_req` edge outside OPERACAO: ignored.
- Counter width is 32 bits and it saturates; it never wraps.
- `rst` mid-session: returns to reset values on the next edge, including factory `data_setup`. The setup module shares system `rst`.

## Configuration
- `SETUP_TIMEOUT_EN` defined: the inactivity counter, the ABORTAR state and `setup_rst` are compiled in.
- `SETUP_TIMEOUT_EN` undefined: the counter and ABORTAR are absent and `setup_rst` is tied to 0. SETUP_ATIVO leaves only on `setup_end`==0.

## Test plan
- Reset -> `data_setup`.bip_time=5, pin1={1,0,0,0,0}, `setup_on`=0, `bcd_out`=FFFFFF, `bcd_enable`=0.
- In OPERACAO, `key_valid`=1 with code 4'h3 -> `op_key_code`=3 and `op_key_valid`=1 one cycle later; `st_key_valid` stays 0.
- `setup_req` pulse -> `setup_on`=1. The setup module drives `data_setup_new` with bip_time=7'd30 and drops `setup_end` -> `data_setup`.bip_time=30 on that edge, `setup_on`=0. `setup_end` returning high -> OPERACAO, `setup_busy`=0.
- With SETUP_TIMEOUT_CYC=20 and no keys -> `setup_rst` pulses exactly 1 cycle at count 19 and `data_setup` is unchanged. A key every 10 cycles -> no abort.
- `setup_end` low in the same cycle the counter hits 19 -> commit, `setup_rst` stays 0.
- `rst` asserted in SETUP_ATIVO after a commit -> `data_setup` returns to factory values and the state is OPERACAO on the next edge.
